// File: rtl/i2c_read_reg.sv
// i2c_read_reg: single-byte I2C register reader.
// Drives a shared I2C master through START + write(reg_address) and then a
// repeated START + 1-byte read + STOP. Returns the byte on read_data with a
// one-cycle done pulse, or pulses message_failure on a missed ACK or timeout.
//
// Optional build macro: I2C_READ_REG_RETRY_EN. When defined, the first failure
// of a transaction re-runs it once from the bus-wait step. Only a second
// failure reports message_failure.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle request, sampled only when idle
//   dev_address         7-bit target address, latched on accepted start
//   reg_address         register pointer, latched on accepted start
//   read_data           last byte read successfully
//   done                success pulse
//   message_failure     failure pulse
//   busy                high while a transaction is in progress
//   i2c_cmd_*           command stream to the I2C master
//   i2c_data_out*       write-data stream to the I2C master
//   i2c_data_in*        read-data stream from the I2C master
//   i2c_bus_busy, i2c_bus_control, i2c_missed_ack   master status
module i2c_read_reg #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TIMER_W        = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] dev_address,
  input  logic [7:0] reg_address,
  output logic [7:0] read_data,
  output logic       done,
  output logic       message_failure,
  output logic       busy,
  output logic [6:0] i2c_cmd_address,
  output logic       i2c_cmd_start,
  output logic       i2c_cmd_read,
  output logic       i2c_cmd_write,
  output logic       i2c_cmd_stop,
  output logic       i2c_cmd_valid,
  input  logic       i2c_cmd_ready,
  output logic [7:0] i2c_data_out,
  output logic       i2c_data_out_valid,
  output logic       i2c_data_out_last,
  input  logic       i2c_data_out_ready,
  input  logic [7:0] i2c_data_in,
  input  logic       i2c_data_in_valid,
  input  logic       i2c_data_in_last,
  output logic       i2c_data_in_ready,
  input  logic       i2c_bus_busy,
  input  logic       i2c_bus_control,
  input  logic       i2c_missed_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BUS, S_CMD_WR, S_DATA_REG,
    S_CMD_RD, S_READ_DATA, S_WAIT_FREE, S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         read_data_q, read_data_d;
  logic [6:0]         cmd_addr_q, cmd_addr_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               busy_q, busy_d;
  logic               cmd_start_q, cmd_start_d;
  logic               cmd_read_q, cmd_read_d;
  logic               cmd_write_q, cmd_write_d;
  logic               cmd_stop_q, cmd_stop_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               dout_valid_q, dout_valid_d;
  logic               din_ready_q, din_ready_d;
  logic               bus_free, timed_out, err;

`ifdef I2C_READ_REG_RETRY_EN
  logic               retry_q, retry_d;
`endif

  // Only one byte is ever requested, so the master's last flag carries no news.
  logic unused_data_in_last;
  assign unused_data_in_last = i2c_data_in_last;

  assign bus_free  = ~i2c_bus_busy & ~i2c_bus_control;
  assign timed_out = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    cmd_addr_d  = cmd_addr_q;
    data_out_d  = data_out_q;
    done_d      = 1'b0;
    err         = 1'b0;
`ifdef I2C_READ_REG_RETRY_EN
    retry_d     = retry_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Output registers double as the latched addresses; payload stays stable.
          cmd_addr_d = dev_address;
          data_out_d = reg_address;
          state_d    = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS:  if (bus_free) state_d = S_CMD_WR;
      S_CMD_WR:    if (i2c_cmd_ready) state_d = S_DATA_REG;
      S_DATA_REG:  if (i2c_data_out_ready) state_d = S_CMD_RD;
      S_CMD_RD:    if (i2c_cmd_ready) state_d = S_READ_DATA;
      S_READ_DATA: begin
        if (i2c_data_in_valid) begin
          read_data_d = i2c_data_in;
          state_d     = S_WAIT_FREE;
        end
      end
      S_WAIT_FREE: begin
        if (bus_free) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FAIL:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    // Failure overrides any handshake or capture decided above.
    if (state_q != S_IDLE && state_q != S_FAIL && (i2c_missed_ack || timed_out)) begin
      err         = 1'b1;
      done_d      = 1'b0;
      read_data_d = read_data_q;
`ifdef I2C_READ_REG_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        state_d = S_WAIT_BUS;
      end else begin
        state_d = S_FAIL;
      end
`else
      state_d = S_FAIL;
`endif
    end

`ifdef I2C_READ_REG_RETRY_EN
    if (state_q == S_IDLE) retry_d = 1'b0;
`endif

    // A retry can re-enter the state it failed in, so clear on err as well.
    if (state_d != state_q || err || state_q == S_IDLE || state_q == S_FAIL) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end

    // Outputs are registered copies of what the next state calls for.
    fail_d       = (state_d == S_FAIL);
    busy_d       = (state_d != S_IDLE);
    cmd_start_d  = (state_d == S_CMD_WR) || (state_d == S_CMD_RD);
    cmd_write_d  = (state_d == S_CMD_WR);
    cmd_read_d   = (state_d == S_CMD_RD);
    cmd_stop_d   = (state_d == S_CMD_RD);
    cmd_valid_d  = (state_d == S_CMD_WR) || (state_d == S_CMD_RD);
    dout_valid_d = (state_d == S_DATA_REG);
    din_ready_d  = (state_d == S_READ_DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      read_data_q  <= '0;
      cmd_addr_q   <= '0;
      data_out_q   <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b0;
      cmd_start_q  <= 1'b0;
      cmd_read_q   <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_stop_q   <= 1'b0;
      cmd_valid_q  <= 1'b0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b0;
`ifdef I2C_READ_REG_RETRY_EN
      retry_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      read_data_q  <= read_data_d;
      cmd_addr_q   <= cmd_addr_d;
      data_out_q   <= data_out_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
      cmd_start_q  <= cmd_start_d;
      cmd_read_q   <= cmd_read_d;
      cmd_write_q  <= cmd_write_d;
      cmd_stop_q   <= cmd_stop_d;
      cmd_valid_q  <= cmd_valid_d;
      dout_valid_q <= dout_valid_d;
      din_ready_q  <= din_ready_d;
`ifdef I2C_READ_REG_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  assign read_data          = read_data_q;
  assign done               = done_q;
  assign message_failure    = fail_q;
  assign busy               = busy_q;
  assign i2c_cmd_address    = cmd_addr_q;
  assign i2c_cmd_start      = cmd_start_q;
  assign i2c_cmd_read       = cmd_read_q;
  assign i2c_cmd_write      = cmd_write_q;
  assign i2c_cmd_stop       = cmd_stop_q;
  assign i2c_cmd_valid      = cmd_valid_q;
  assign i2c_data_out       = data_out_q;
  assign i2c_data_out_valid = dout_valid_q;
  assign i2c_data_out_last  = dout_valid_q;
  assign i2c_data_in_ready  = din_ready_q;

endmodule

// File: tb/tb_i2c_read_reg.sv
// tb_i2c_read_reg: directed bench for i2c_read_reg. The bench plays the I2C
// master by hand, step by step, and checks each registered output against
// hand-computed values. Built with TIMEOUT_CYCLES=50.
module tb_i2c_read_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] dev_address;
  logic [7:0] reg_address;
  logic [7:0] read_data;
  logic       done, message_failure, busy;
  logic [6:0] i2c_cmd_address;
  logic       i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_stop;
  logic       i2c_cmd_valid, i2c_cmd_ready;
  logic [7:0] i2c_data_out;
  logic       i2c_data_out_valid, i2c_data_out_last, i2c_data_out_ready;
  logic [7:0] i2c_data_in;
  logic       i2c_data_in_valid, i2c_data_in_last, i2c_data_in_ready;
  logic       i2c_bus_busy, i2c_bus_control, i2c_missed_ack;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  i2c_read_reg #(
    .TIMEOUT_CYCLES(50),
    .TIMER_W(17)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dev_address(dev_address),
    .reg_address(reg_address),
    .read_data(read_data),
    .done(done),
    .message_failure(message_failure),
    .busy(busy),
    .i2c_cmd_address(i2c_cmd_address),
    .i2c_cmd_start(i2c_cmd_start),
    .i2c_cmd_read(i2c_cmd_read),
    .i2c_cmd_write(i2c_cmd_write),
    .i2c_cmd_stop(i2c_cmd_stop),
    .i2c_cmd_valid(i2c_cmd_valid),
    .i2c_cmd_ready(i2c_cmd_ready),
    .i2c_data_out(i2c_data_out),
    .i2c_data_out_valid(i2c_data_out_valid),
    .i2c_data_out_last(i2c_data_out_last),
    .i2c_data_out_ready(i2c_data_out_ready),
    .i2c_data_in(i2c_data_in),
    .i2c_data_in_valid(i2c_data_in_valid),
    .i2c_data_in_last(i2c_data_in_last),
    .i2c_data_in_ready(i2c_data_in_ready),
    .i2c_bus_busy(i2c_bus_busy),
    .i2c_bus_control(i2c_bus_control),
    .i2c_missed_ack(i2c_missed_ack)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (message_failure) fail_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a transaction from the cycle the DUT sits in S_CMD_WR to done.
  task automatic finish_from_cmd_wr(input logic [6:0] dev, input logic [7:0] rg,
                                    input logic [7:0] byte_v, input int cw, input int dw);
    logic stable;
    int   d0;
    check("wr_valid", i2c_cmd_valid, 1);
    check("wr_flags", {i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_stop}, 4'b1010);
    check("wr_addr", i2c_cmd_address, dev);
    if (cw > 0) begin
      stable = 1'b1;
      repeat (cw) begin
        tick();
        if (!(i2c_cmd_valid && i2c_cmd_write && i2c_cmd_address == dev)) stable = 1'b0;
      end
      check("wr_hold", stable, 1);
    end
    i2c_cmd_ready = 1'b1; tick(); i2c_cmd_ready = 1'b0;
    check("wr_drop", i2c_cmd_valid, 0);
    check("reg_valid_last", {i2c_data_out_valid, i2c_data_out_last}, 2'b11);
    check("reg_byte", i2c_data_out, rg);
    if (dw > 0) begin
      stable = 1'b1;
      repeat (dw) begin
        tick();
        if (!(i2c_data_out_valid && i2c_data_out_last && i2c_data_out == rg)) stable = 1'b0;
      end
      check("reg_hold", stable, 1);
    end
    i2c_data_out_ready = 1'b1; tick(); i2c_data_out_ready = 1'b0;
    check("reg_drop", i2c_data_out_valid, 0);
    check("rd_valid", i2c_cmd_valid, 1);
    check("rd_flags", {i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_stop}, 4'b1101);
    i2c_cmd_ready = 1'b1; tick(); i2c_cmd_ready = 1'b0;
    check("rd_drop", i2c_cmd_valid, 0);
    check("din_ready", i2c_data_in_ready, 1);
    i2c_bus_busy = 1'b1;
    tick(); tick();
    i2c_data_in = byte_v; i2c_data_in_valid = 1'b1; i2c_data_in_last = 1'b1;
    tick();
    i2c_data_in_valid = 1'b0; i2c_data_in_last = 1'b0;
    check("din_drop", i2c_data_in_ready, 0);
    check("rdata", read_data, byte_v);
    check("early_done", done, 0);
    tick();
    check("done_wait_bus", done, 0);
    i2c_bus_busy = 1'b0;
    d0 = done_cnt;
    tick();
    check("done", done, 1);
    check("idle_busy", busy, 0);
    tick();
    check("done_once", done_cnt - d0, 1);
  endtask

  task automatic run_read(input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] byte_v, input int cw, input int dw);
    dev_address = dev; reg_address = rg; start = 1'b1;
    tick();
    start = 1'b0;
    dev_address = ~dev; reg_address = ~rg;   // latched copies must be used
    check("busy", busy, 1);
    check("wait_bus_no_cmd", i2c_cmd_valid, 0);
    tick();
    finish_from_cmd_wr(dev, rg, byte_v, cw, dw);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int f0, d0, n;
    logic saw_valid;
    reset = 1'b1; start = 1'b0; dev_address = '0; reg_address = '0;
    i2c_cmd_ready = 1'b0; i2c_data_out_ready = 1'b0; i2c_data_in = '0;
    i2c_data_in_valid = 1'b0; i2c_data_in_last = 1'b0;
    i2c_bus_busy = 1'b0; i2c_bus_control = 1'b0; i2c_missed_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_rdata", read_data, 8'h00);
    check("rst_pulses", {done, message_failure, busy}, 3'b000);
    check("rst_valids", {i2c_cmd_valid, i2c_data_out_valid, i2c_data_in_ready}, 3'b000);
    check("rst_payload", {i2c_cmd_address, i2c_data_out}, 15'h0);

    // Backpressure, then nominal.
    run_read(7'h29, 8'h8C, 8'h5A, 20, 5);
    run_read(7'h29, 8'h8C, 8'hA5, 0, 0);
    check("no_fail_nominal", fail_cnt, 0);

`ifndef I2C_READ_REG_RETRY_EN
    // Missed ACK in S_DATA_REG, colliding with a ready handshake.
    dev_address = 7'h29; reg_address = 8'h8C; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    i2c_cmd_ready = 1'b1; tick(); i2c_cmd_ready = 1'b0;
    check("nack_in_reg", i2c_data_out_valid, 1);
    i2c_missed_ack = 1'b1; i2c_data_out_ready = 1'b1;
    tick();
    i2c_missed_ack = 1'b0; i2c_data_out_ready = 1'b0;
    check("nack_fail", message_failure, 1);
    check("nack_valids", {i2c_cmd_valid, i2c_data_out_valid}, 2'b00);
    check("nack_busy1", busy, 1);
    tick();
    check("nack_fail_pulse", message_failure, 0);
    check("nack_busy2", busy, 0);
    check("nack_rdata", read_data, 8'hA5);
`else
    // First attempt NACKed, second clean.
    f0 = fail_cnt;
    dev_address = 7'h29; reg_address = 8'h8C; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    i2c_cmd_ready = 1'b1; tick(); i2c_cmd_ready = 1'b0;
    i2c_missed_ack = 1'b1; tick(); i2c_missed_ack = 1'b0;
    check("retry_no_fail", message_failure, 0);
    check("retry_busy", busy, 1);
    check("retry_valids", {i2c_cmd_valid, i2c_data_out_valid}, 2'b00);
    tick();
    finish_from_cmd_wr(7'h29, 8'h8C, 8'hC3, 0, 0);
    check("retry_fail_cnt", fail_cnt - f0, 0);

    // Two NACKs: exactly one failure.
    f0 = fail_cnt;
    dev_address = 7'h29; reg_address = 8'h8C; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    i2c_missed_ack = 1'b1; tick(); i2c_missed_ack = 1'b0;
    check("retry2_first", message_failure, 0);
    tick();
    check("retry2_cmd", i2c_cmd_valid, 1);
    i2c_missed_ack = 1'b1; tick(); i2c_missed_ack = 1'b0;
    check("retry2_fail", message_failure, 1);
    tick();
    check("retry2_idle", busy, 0);
    check("retry2_fail_cnt", fail_cnt - f0, 1);
    check("retry2_rdata", read_data, 8'hC3);
`endif

    // Timeout with the bus stuck busy.
    f0 = fail_cnt;
    i2c_bus_busy = 1'b1;
    dev_address = 7'h11; reg_address = 8'h22; start = 1'b1;
    tick(); start = 1'b0;
    n = 0; saw_valid = 1'b0;
    while (!message_failure && n < 300) begin
      tick();
      n++;
      if (i2c_cmd_valid) saw_valid = 1'b1;
    end
`ifdef I2C_READ_REG_RETRY_EN
    check("timeout_cycles", n, 100);
`else
    check("timeout_cycles", n, 50);
`endif
    check("timeout_no_cmd", saw_valid, 0);
    i2c_bus_busy = 1'b0;
    tick();
    check("timeout_idle", busy, 0);
    check("timeout_fail_cnt", fail_cnt - f0, 1);

    // Reset while in S_READ_DATA.
    i2c_cmd_ready = 1'b1; i2c_data_out_ready = 1'b1;
    dev_address = 7'h29; reg_address = 8'h8C; start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    check("pre_rst_din_ready", i2c_data_in_ready, 1);
    i2c_cmd_ready = 1'b0; i2c_data_out_ready = 1'b0;
    d0 = done_cnt; f0 = fail_cnt;
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_rdata", read_data, 8'h00);
    check("mid_rst_flags", {done, message_failure, busy, i2c_cmd_valid,
                            i2c_data_out_valid, i2c_data_in_ready}, 6'b0);
    check("mid_rst_payload", {i2c_cmd_address, i2c_data_out}, 15'h0);
    tick();
    check("mid_rst_no_pulse", (done_cnt - d0) + (fail_cnt - f0), 0);
    run_read(7'h29, 8'h8C, 8'h3C, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_read_reg.md
Name: i2c_read_reg

Overview:
- Single-byte I2C register reader; the read-side companion of the register-write sequencer in SensorModule.
- Given dev_address and reg_address plus a start pulse, it drives the shared I2C master through this sequence:
  - START + write of reg_address, no stop;
  - repeated START + 1-byte read + STOP.
- Returns the byte on read_data with a done pulse, or pulses message_failure on missed ACK or timeout.
- Sits between sensor-config/poll FSMs and the I2C master command/data streams.

Parameters:
- TIMEOUT_CYCLES, 100000: max clk cycles spent in any single wait state before failure.
- TIMER_W, 17: width of the internal timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in S_IDLE
- dev_address  in  7  7-bit target address, latched on accepted start
- reg_address  in  8  register pointer, latched on accepted start
- read_data  out  8  last byte read; held until next successful read
- done  out  1  one-cycle pulse on success
- message_failure  out  1  one-cycle pulse on missed ACK or timeout
- busy  out  1  high whenever state != S_IDLE
- i2c_cmd_address  out  7  device address to master
- i2c_cmd_start / i2c_cmd_read / i2c_cmd_write / i2c_cmd_stop  out  1 each  command flags
- i2c_cmd_valid  out  1  command valid
- i2c_cmd_ready  in  1  master accepts command
- i2c_data_out  out  8  write byte to master
- i2c_data_out_valid / i2c_data_out_last  out  1 each
- i2c_data_out_ready  in  1
- i2c_data_in  in  8  read byte from master
- i2c_data_in_valid / i2c_data_in_last  in  1 each
- i2c_data_in_ready  out  1
- i2c_bus_busy / i2c_bus_control / i2c_missed_ack  in  1 each

Behaviour:
- All outputs registered. Reset values: read_data=0x00; done, message_failure and busy=0; all cmd flags and valids=0; i2c_data_out=0x00; i2c_cmd_address=0; state=S_IDLE; timer=0.
- Handshake: any valid, once raised, holds with stable payload until the same-cycle ready; it drops the cycle after transfer. i2c_data_in_ready is high only in S_READ_DATA.
- Timer: clears on every state change and increments in wait states. Reaching TIMEOUT_CYCLES-1 means failure.
- States:
  - S_IDLE: start=1 latches addresses and goes to S_WAIT_BUS. start while busy is ignored.
  - S_WAIT_BUS: waits for ~i2c_bus_busy & ~i2c_bus_control, then goes to S_CMD_WR.
  - S_CMD_WR: cmd_start=1, cmd_write=1, cmd_stop=0, cmd_valid=1. On handshake goes to S_DATA_REG.
  - S_DATA_REG: data_out=reg_address, data_out_last=1, data_out_valid=1. On handshake goes to S_CMD_RD.
  - S_CMD_RD: cmd_start=1 (repeated start), cmd_read=1, cmd_stop=1, cmd_valid=1. On handshake goes to S_READ_DATA.
  - S_READ_DATA: on i2c_data_in_valid, captures read_data <= i2c_data_in and goes to S_WAIT_FREE. data_in_last is ignored; one byte only.
  - S_WAIT_FREE: waits for ~i2c_bus_busy & ~i2c_bus_control, then pulses done and returns to S_IDLE.
  - S_FAIL: pulses message_failure, forces all valids low, returns to S_IDLE the next cycle.
- i2c_missed_ack=1 in any non-IDLE state goes to S_FAIL. It has priority over handshakes in the same cycle.
- A timeout in any non-IDLE state goes to S_FAIL.
- A failed transaction does not modify read_data.
- reset mid-transaction: next cycle is S_IDLE with all outputs at reset values. No done or failure pulse.
- done and message_failure are mutually exclusive and never asserted on consecutive transactions without an intervening S_IDLE cycle.
- Latency with an always-ready master: done asserts 6 cycles after start plus master bus time.

Optional Feature:
- I2C_READ_REG_RETRY_EN defined:
  - The first failure (missed ACK or timeout) does not pulse message_failure.
  - Instead the FSM waits one S_WAIT_BUS pass and restarts at S_CMD_WR with the latched addresses.
  - A second failure pulses message_failure.
  - The retry flag clears on S_IDLE.
- Undefined: the first failure goes directly to S_FAIL. No retry logic is synthesised.

Test Plan:
- Nominal: dev=0x29, reg=0x8C, master returns 0xA5 -> command sequence is write, data 0x8C last=1, read+stop; read_data=0xA5; one-cycle done; message_failure=0.
- Backpressure: cmd_ready held low 20 cycles, data_out_ready low 5 cycles -> valids and payloads stable throughout; single transfer each; done still asserts.
- Missed ACK during S_DATA_REG -> message_failure pulse, read_data keeps previous 0xA5, busy=0 within 2 cycles.
- Timeout: TIMEOUT_CYCLES=50, i2c_bus_busy stuck high -> message_failure at cycle 50 after entering S_WAIT_BUS; no cmd_valid ever.
- Reset at S_READ_DATA -> all outputs at reset values next cycle; a following start completes normally.
- RETRY_EN: missed_ack on first attempt, clean second attempt -> no message_failure; done with correct byte. Two missed_acks -> exactly one message_failure.
